// File: rtl/vram_scanout_arbiter.sv
// vram_scanout_arbiter: line-buffered 1bpp scanout with prefetch-priority CPU access to single-port VRAM
module vram_scanout_arbiter #(
  parameter int WORDS_PER_LINE = 50,
  parameter int LAST_ACTIVE_LINE = 599,
  parameter int LAST_LINE = 665,
  parameter int FETCH_STA = 800
) (
  input  logic        clk_pix,
  input  logic        rst_pix_n,
  input  logic [10:0] sx,
  input  logic [9:0]  sy,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [14:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  output logic [14:0] mem_addr,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        pix,
  output logic        fetch_busy
);
  localparam int IW = $clog2(WORDS_PER_LINE);
  localparam int CW = $clog2(WORDS_PER_LINE + 1);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t state;
  logic [CW-1:0] idx;
  logic [IW-1:0] widx;
  logic [14:0] fcnt, faddr;
  logic [15:0] linebuf [WORDS_PER_LINE];
  logic [15:0] rdata_q;
  logic next_act, start, fetching, accept, ack, tag;
  always_comb begin
    next_act = (sy < 10'(LAST_ACTIVE_LINE)) || (sy == 10'(LAST_LINE));
    start = rst_pix_n && state == IDLE && sx == 11'(FETCH_STA) && next_act;
    fetching = start || state == FETCH;
    accept = rst_pix_n && state == IDLE && !start && cpu_req && !ack;
    faddr = (start && sy == 10'(LAST_LINE)) ? 15'd0 : fcnt;
    mem_addr = fetching ? faddr : accept ? cpu_addr : 15'd0;
    mem_we = accept && cpu_we;
    mem_wdata = accept ? cpu_wdata : 16'd0;
    fetch_busy = start || state != IDLE;
    cpu_ack = ack;
    cpu_rdata = (ack && tag) ? mem_rdata : rdata_q;
    widx = IW'(idx - 1'b1);
  end
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      state <= IDLE;
      idx <= '0;
      fcnt <= '0;
      ack <= 1'b0;
      tag <= 1'b0;
      rdata_q <= '0;
      pix <= 1'b0;
    end else begin
      ack <= accept;
      tag <= accept && !cpu_we;
      rdata_q <= cpu_rdata;
      pix <= (sx <= 11'd799 && sy <= 10'(LAST_ACTIVE_LINE)) ? linebuf[sx[IW+3:4]][~sx[3:0]] : 1'b0;
      if (fetching) fcnt <= faddr + 15'd1;
      if (start) begin
        state <= FETCH;
        idx <= CW'(1);
      end else if (state == FETCH) begin
        if (idx == CW'(WORDS_PER_LINE - 1)) state <= DRAIN;
        idx <= idx + 1'b1;
      end else if (state == DRAIN) begin
        state <= IDLE;
        idx <= '0;
      end
    end
  end
  // read data lags the fetch address by one cycle, so the write lands in linebuf[idx-1]
  always_ff @(posedge clk_pix)
    if (state == FETCH || state == DRAIN) linebuf[widx] <= mem_rdata;
endmodule

// File: tb/tb_vram_scanout_arbiter.sv
// tb_vram_scanout_arbiter: directed vectors and corner sequences for vram_scanout_arbiter
module tb_vram_scanout_arbiter;
  logic clk = 1'b0;
  logic rst_pix_n;
  logic [10:0] sx;
  logic [9:0] sy;
  logic cpu_req, cpu_we;
  logic [14:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic cpu_ack;
  logic [15:0] cpu_rdata;
  logic [14:0] mem_addr;
  logic mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic pix, fetch_busy;
  logic [15:0] vmem [32768];
  logic loaded = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int x; int y; bit rq; bit we; int a; int wd;
    bit e_ack; bit e_we; bit e_busy; bit ca; int e_addr; int e_rd;
  } vec_t;
  vec_t tbl [11];

  always #5 clk = ~clk;

  vram_scanout_arbiter dut (
    .clk_pix(clk), .rst_pix_n(rst_pix_n), .sx(sx), .sy(sy),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pix(pix), .fetch_busy(fetch_busy)
  );

  function automatic logic [15:0] pat(input int i);
    if (i == 50) return 16'h8000;
    if (i > 50 && i < 100) return 16'h0000;
    return 16'(i * 40503 + 12345);
  endfunction

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 32768; i++) vmem[i] <= pat(i);
      loaded <= 1'b1;
    end else if (mem_we) vmem[mem_addr] <= mem_wdata;
    mem_rdata <= vmem[mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at sx=%0d sy=%0d: got %h want %h", nm, sx, sy, act, exp);
    end
  endtask

  task automatic cyc(input int x, input int y, input bit rq = 1'b0, input bit we = 1'b0, input int a = 0, input int wd = 0);
    @(posedge clk);
    #1;
    sx = 11'(x);
    sy = 10'(y);
    cpu_req = rq;
    cpu_we = we;
    cpu_addr = 15'(a);
    cpu_wdata = 16'(wd);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ack"}, cpu_ack, 0);
    chk({nm, "_rdata"}, cpu_rdata, 0);
    chk({nm, "_we"}, mem_we, 0);
    chk({nm, "_addr"}, mem_addr, 0);
    chk({nm, "_wdata"}, mem_wdata, 0);
    chk({nm, "_pix"}, pix, 0);
    chk({nm, "_busy"}, fetch_busy, 0);
  endtask

  initial begin
    int p200, busy_n;
    bit acked;
    logic [15:0] w;
    p200 = int'(pat('h200));
    tbl[0]  = '{100, 620, 1, 1, 30000, 'h1111, 0, 1, 0, 1, 30000, p200};
    tbl[1]  = '{101, 620, 1, 1, 30000, 'h1111, 1, 0, 0, 0, 0, p200};
    tbl[2]  = '{102, 620, 1, 1, 30001, 'h2222, 0, 1, 0, 1, 30001, p200};
    tbl[3]  = '{103, 620, 1, 1, 30001, 'h2222, 1, 0, 0, 0, 0, p200};
    tbl[4]  = '{104, 620, 1, 1, 32767, 'h3333, 0, 1, 0, 1, 32767, p200};
    tbl[5]  = '{105, 620, 1, 1, 32767, 'h3333, 1, 0, 0, 0, 0, p200};
    tbl[6]  = '{106, 620, 0, 0, 0, 0, 0, 0, 0, 0, 0, p200};
    tbl[7]  = '{800, 620, 0, 0, 0, 0, 0, 0, 0, 0, 0, p200};
    tbl[8]  = '{800, 599, 0, 0, 0, 0, 0, 0, 0, 0, 0, p200};
    tbl[9]  = '{801, 599, 1, 0, 30000, 0, 0, 0, 0, 1, 30000, p200};
    tbl[10] = '{802, 599, 1, 0, 30000, 0, 1, 0, 0, 0, 0, 'h1111};
    rst_pix_n = 1'b0;
    repeat (3) cyc(0, 0);
    chk_zero("reset");
    rst_pix_n = 1'b1;
    // prefetch of line 0 with a CPU read held off until it finishes
    acked = 1'b0;
    busy_n = 0;
    for (int s = 795; s <= 860; s++) begin
      cyc(s, 665, s >= 800 && !acked, 1'b0, 'h123);
      if (fetch_busy) busy_n++;
      chk("busy665", fetch_busy, s >= 800 && s <= 850);
      chk("ack665", cpu_ack, s == 852);
      if (s >= 800 && s <= 849) begin
        chk("fetch_addr", mem_addr, s - 800);
        chk("fetch_we", mem_we, 0);
      end
      if (cpu_ack) begin
        acked = 1'b1;
        chk("rd123", cpu_rdata, pat('h123));
      end
    end
    chk("busy_len", busy_n, 51);
    // line 0 display, plus a CPU read accepted the cycle before the line 1 prefetch
    for (int s = 0; s <= 851; s++) begin
      cyc(s, 0, s == 799, 1'b0, 'h200);
      if (s >= 1 && s <= 800) begin
        w = pat((s - 1) >> 4);
        chk("pix_l0", pix, w[15 - ((s - 1) & 15)]);
      end
      if (s == 799) chk("cpu_addr799", mem_addr, 'h200);
      if (s == 800) begin
        chk("ack800", cpu_ack, 1);
        chk("rd200", cpu_rdata, pat('h200));
        chk("l1_addr", mem_addr, 50);
      end
      if (s == 801) chk("ack801", cpu_ack, 0);
    end
    for (int s = 0; s <= 799; s++) begin
      cyc(s, 1);
      if (s >= 1) chk("pix_l1", pix, s == 1);
    end
    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].x, tbl[i].y, tbl[i].rq, tbl[i].we, tbl[i].a, tbl[i].wd);
      chk("tbl_ack", cpu_ack, tbl[i].e_ack);
      chk("tbl_we", mem_we, tbl[i].e_we);
      chk("tbl_busy", fetch_busy, tbl[i].e_busy);
      chk("tbl_rdata", cpu_rdata, tbl[i].e_rd);
      if (tbl[i].ca) chk("tbl_addr", mem_addr, tbl[i].e_addr);
    end
    chk("mem30000", vmem[30000], 'h1111);
    chk("mem30001", vmem[30001], 'h2222);
    chk("mem32767", vmem[32767], 'h3333);
    // reset in the middle of a prefetch
    for (int s = 795; s <= 820; s++) begin
      cyc(s, 10);
      if (s == 800) chk("l11_addr", mem_addr, 100);
      if (s == 820) begin
        chk("l11_addr820", mem_addr, 120);
        chk("busy820", fetch_busy, 1);
      end
    end
    rst_pix_n = 1'b0;
    #1;
    chk_zero("midrst");
    cyc(821, 10);
    cyc(822, 10);
    chk_zero("midrst_hold");
    rst_pix_n = 1'b1;
    for (int s = 823; s <= 899; s++) begin
      cyc(s, 10);
      chk("post_rst_busy", fetch_busy, 0);
      chk("post_rst_ack", cpu_ack, 0);
    end
    for (int s = 795; s <= 852; s++) begin
      cyc(s, 11);
      chk("restart_busy", fetch_busy, s >= 800 && s <= 850);
      chk("restart_ack", cpu_ack, 0);
      if (s >= 800 && s <= 849) chk("restart_addr", mem_addr, s - 800);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
